// File: rtl/itlb_ctrl.sv
// itlb_ctrl: boot loader, tlbwrite sequencer and miss/stall controller for the 4-entry FETCH ITLB.
// Defining ITLB_FLUSH_EN adds a flush input and a one-cycle FLUSH state that invalidates every entry.
module itlb_ctrl #(
   parameter int num_tlb_lines     = 4,
   parameter int tag_bits_per_addr = 10
) (
   input  logic                         clk,
   input  logic                         reset,
`ifdef ITLB_FLUSH_EN
   input  logic                         flush,
`endif
   input  logic                         lookup_req,
   input  logic [tag_bits_per_addr-1:0] lookup_vpn,
   input  logic                         tlb_hit,
   input  logic                         wr_req,
   input  logic [tag_bits_per_addr-1:0] wr_vpn,
   input  logic [tag_bits_per_addr-1:0] wr_ppn,
   output logic                         wr_ready,
   output logic [num_tlb_lines-1:0]     tlb_we,
   output logic [tag_bits_per_addr-1:0] tlb_vpn_d,
   output logic [tag_bits_per_addr-1:0] tlb_ppn_d,
   output logic [num_tlb_lines-1:0]     tlb_valid_we,
   output logic [num_tlb_lines-1:0]     tlb_valid_d,
   output logic                         fetch_stall,
   output logic                         miss_exc,
   output logic [tag_bits_per_addr-1:0] miss_vpn,
   input  logic                         exc_ack,
   output logic                         init_done
);

   localparam logic [2:0] BOOT0 = 3'd0;
   localparam logic [2:0] BOOT1 = 3'd1;
   localparam logic [2:0] IDLE  = 3'd2;
   localparam logic [2:0] WRITE = 3'd3;
   localparam logic [2:0] MISS  = 3'd4;
`ifdef ITLB_FLUSH_EN
   localparam logic [2:0] FLUSH = 3'd5;
`endif

   localparam logic [tag_bits_per_addr-1:0] BOOT0_VPN = tag_bits_per_addr'(8'h08);
   localparam logic [tag_bits_per_addr-1:0] BOOT0_PPN = tag_bits_per_addr'(8'h00);
   localparam logic [tag_bits_per_addr-1:0] BOOT1_VPN = tag_bits_per_addr'(8'h09);
   localparam logic [tag_bits_per_addr-1:0] BOOT1_PPN = tag_bits_per_addr'(8'h01);
   localparam logic [tag_bits_per_addr-1:0] ZERO_TAG  = {tag_bits_per_addr{1'b0}};

   logic [2:0]                   state_r;
   logic [2:0]                   state_nxt_s;
   logic                         ret_miss_r;
   logic [1:0]                   victim_r;
   logic [tag_bits_per_addr-1:0] wr_vpn_r;
   logic [tag_bits_per_addr-1:0] wr_ppn_r;
   logic [3:0]                   sh_valid_r;
   logic [tag_bits_per_addr-1:0] sh_vpn_r [4];
   logic [1:0]                   rr_r;
   logic [tag_bits_per_addr-1:0] miss_vpn_r;

   logic                         flush_s;
   logic                         wr_ready_s;
   logic                         accept_wr_s;
   logic                         capture_miss_s;
   logic [3:0]                   match_vec_s;
   logic [2:0]                   match_sel_s;
   logic [2:0]                   free_sel_s;
   logic [1:0]                   victim_s;
   logic                         rr_adv_s;
   logic [3:0]                   victim_oh_s;

   // Returns {found, index} of the lowest set bit.
   function automatic logic [2:0] first_set(input logic [3:0] v);
      casez (v)
         4'b???1: first_set = {1'b1, 2'd0};
         4'b??10: first_set = {1'b1, 2'd1};
         4'b?100: first_set = {1'b1, 2'd2};
         4'b1000: first_set = {1'b1, 2'd3};
         default: first_set = {1'b0, 2'd0};
      endcase
   endfunction

`ifdef ITLB_FLUSH_EN
   assign flush_s = flush;
`else
   assign flush_s = 1'b0;
`endif

   assign wr_ready_s     = (state_r == IDLE) || (state_r == MISS);
   assign accept_wr_s    = wr_ready_s && wr_req && !flush_s;
   assign capture_miss_s = (state_r == IDLE) && !flush_s && !wr_req && lookup_req && !tlb_hit;
   assign victim_oh_s    = 4'b0001 << victim_r;

   // Victim choice: overwrite an existing mapping, else lowest free entry, else round-robin.
   always_comb begin
      match_vec_s = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         match_vec_s[i] = sh_valid_r[i] & (sh_vpn_r[i] == wr_vpn);
      end
      match_sel_s = first_set(match_vec_s);
      free_sel_s  = first_set(~sh_valid_r);
      rr_adv_s    = 1'b0;
      if (match_sel_s[2]) begin
         victim_s = match_sel_s[1:0];
      end else if (free_sel_s[2]) begin
         victim_s = free_sel_s[1:0];
      end else begin
         victim_s = rr_r;
         rr_adv_s = 1'b1;
      end
   end

   // Next-state selection; in IDLE and MISS flush beats write, and write beats miss/ack.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         BOOT0: state_nxt_s = BOOT1;
         BOOT1: state_nxt_s = IDLE;
         IDLE: begin
`ifdef ITLB_FLUSH_EN
            if (flush_s) state_nxt_s = FLUSH;
            else
`endif
            if (wr_req) state_nxt_s = WRITE;
            else if (lookup_req && !tlb_hit) state_nxt_s = MISS;
            else state_nxt_s = IDLE;
         end
         MISS: begin
`ifdef ITLB_FLUSH_EN
            if (flush_s) state_nxt_s = FLUSH;
            else
`endif
            if (wr_req) state_nxt_s = WRITE;
            else if (exc_ack) state_nxt_s = IDLE;
            else state_nxt_s = MISS;
         end
         WRITE: begin
            if (ret_miss_r) state_nxt_s = MISS;
            else state_nxt_s = IDLE;
         end
`ifdef ITLB_FLUSH_EN
         FLUSH: state_nxt_s = IDLE;
`endif
         default: state_nxt_s = BOOT0;
      endcase
   end

   // State, write latches, shadows, round-robin pointer and miss capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= BOOT0;
         ret_miss_r <= 1'b0;
         victim_r   <= 2'd0;
         wr_vpn_r   <= ZERO_TAG;
         wr_ppn_r   <= ZERO_TAG;
         sh_valid_r <= 4'b0000;
         for (int i = 0; i < 4; i++) sh_vpn_r[i] <= ZERO_TAG;
         rr_r       <= 2'd0;
         miss_vpn_r <= ZERO_TAG;
      end else begin
         state_r <= state_nxt_s;
         case (state_r)
            BOOT0: begin
               sh_valid_r  <= 4'b0001;
               sh_vpn_r[0] <= BOOT0_VPN;
            end
            BOOT1: begin
               sh_valid_r[1] <= 1'b1;
               sh_vpn_r[1]   <= BOOT1_VPN;
               rr_r          <= 2'd2;
            end
            IDLE, MISS: begin
               if (accept_wr_s) begin
                  wr_vpn_r   <= wr_vpn;
                  wr_ppn_r   <= wr_ppn;
                  victim_r   <= victim_s;
                  ret_miss_r <= (state_r == MISS);
                  if (rr_adv_s) rr_r <= rr_r + 2'd1;
               end
               if (capture_miss_s) miss_vpn_r <= lookup_vpn;
            end
            WRITE: begin
               sh_valid_r[victim_r] <= 1'b1;
               sh_vpn_r[victim_r]   <= wr_vpn_r;
            end
`ifdef ITLB_FLUSH_EN
            FLUSH: begin
               sh_valid_r <= 4'b0000;
               rr_r       <= 2'd0;
            end
`endif
            default: ret_miss_r <= 1'b0;
         endcase
      end
   end

   // Output decode from the registered state; reset forces the safe idle values.
   always_comb begin
      tlb_we       = 4'b0000;
      tlb_vpn_d    = ZERO_TAG;
      tlb_ppn_d    = ZERO_TAG;
      tlb_valid_we = 4'b0000;
      tlb_valid_d  = 4'b0000;
      fetch_stall  = 1'b1;
      wr_ready     = 1'b0;
      miss_exc     = 1'b0;
      if (reset) begin
         fetch_stall = 1'b1;
      end else begin
         case (state_r)
            BOOT0: begin
               tlb_we       = 4'b0001;
               tlb_vpn_d    = BOOT0_VPN;
               tlb_ppn_d    = BOOT0_PPN;
               tlb_valid_we = 4'b1111;
               tlb_valid_d  = 4'b0001;
            end
            BOOT1: begin
               tlb_we       = 4'b0010;
               tlb_vpn_d    = BOOT1_VPN;
               tlb_ppn_d    = BOOT1_PPN;
               tlb_valid_we = 4'b0010;
               tlb_valid_d  = 4'b0010;
            end
            IDLE: begin
               wr_ready    = 1'b1;
               fetch_stall = 1'b0;
            end
            WRITE: begin
               tlb_we       = victim_oh_s;
               tlb_vpn_d    = wr_vpn_r;
               tlb_ppn_d    = wr_ppn_r;
               tlb_valid_we = victim_oh_s;
               tlb_valid_d  = victim_oh_s;
            end
            MISS: begin
               miss_exc = 1'b1;
               wr_ready = 1'b1;
            end
`ifdef ITLB_FLUSH_EN
            FLUSH: tlb_valid_we = 4'b1111;
`endif
            default: fetch_stall = 1'b1;
         endcase
      end
   end

   assign miss_vpn  = reset ? ZERO_TAG : miss_vpn_r;
   assign init_done = !reset && (state_r != BOOT0) && (state_r != BOOT1);

endmodule

// File: tb/tb_itlb_ctrl.sv
// Self-checking bench for itlb_ctrl: per-scenario tasks plus a scoreboard of expected TLB writes.
module tb_itlb_ctrl;

   logic       clk;
   logic       reset;
   logic       lookup_req;
   logic [9:0] lookup_vpn;
   logic       tlb_hit;
   logic       wr_req;
   logic [9:0] wr_vpn;
   logic [9:0] wr_ppn;
   logic       wr_ready;
   logic [3:0] tlb_we;
   logic [9:0] tlb_vpn_d;
   logic [9:0] tlb_ppn_d;
   logic [3:0] tlb_valid_we;
   logic [3:0] tlb_valid_d;
   logic       fetch_stall;
   logic       miss_exc;
   logic [9:0] miss_vpn;
   logic       exc_ack;
   logic       init_done;
`ifdef ITLB_FLUSH_EN
   logic       flush;
`endif

   int errors = 0;
   int checks = 0;
   logic mon_en = 1'b0;

   typedef struct packed {
      logic [3:0] we;
      logic [9:0] vpn;
      logic [9:0] ppn;
   } wr_exp_t;
   wr_exp_t exp_q[$];

   // Reference model of TLB occupancy, written from the victim rules.
   logic       m_valid [4];
   logic [9:0] m_vpn   [4];
   int         m_rr;

   itlb_ctrl dut (
      .clk(clk), .reset(reset),
`ifdef ITLB_FLUSH_EN
      .flush(flush),
`endif
      .lookup_req(lookup_req), .lookup_vpn(lookup_vpn), .tlb_hit(tlb_hit),
      .wr_req(wr_req), .wr_vpn(wr_vpn), .wr_ppn(wr_ppn), .wr_ready(wr_ready),
      .tlb_we(tlb_we), .tlb_vpn_d(tlb_vpn_d), .tlb_ppn_d(tlb_ppn_d),
      .tlb_valid_we(tlb_valid_we), .tlb_valid_d(tlb_valid_d),
      .fetch_stall(fetch_stall), .miss_exc(miss_exc), .miss_vpn(miss_vpn),
      .exc_ack(exc_ack), .init_done(init_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard consumer: every post-boot TLB write must match the oldest expected write.
   always @(negedge clk) begin
      #2;
      if (mon_en && !reset && tlb_we !== 4'b0000) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: tlb_we=%b with no write expected", tlb_we);
         end else begin
            wr_exp_t e;
            e = exp_q.pop_front();
            if (tlb_we !== e.we || tlb_vpn_d !== e.vpn || tlb_ppn_d !== e.ppn ||
                tlb_valid_we !== e.we || (tlb_valid_d & e.we) !== e.we) begin
               errors++;
               $display("FAIL sb_write: got we=%b vpn=%h ppn=%h vwe=%b vd=%b, want we=%b vpn=%h ppn=%h",
                        tlb_we, tlb_vpn_d, tlb_ppn_d, tlb_valid_we, tlb_valid_d, e.we, e.vpn, e.ppn);
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   function automatic int model_pick(input logic [9:0] vpn);
      int v;
      logic found;
      found = 1'b0;
      v = 0;
      for (int i = 0; i < 4; i++)
         if (!found && m_valid[i] && m_vpn[i] == vpn) begin found = 1'b1; v = i; end
      for (int i = 0; i < 4; i++)
         if (!found && !m_valid[i]) begin found = 1'b1; v = i; end
      if (!found) begin
         v = m_rr;
         m_rr = (m_rr + 1) % 4;
      end
      m_valid[v] = 1'b1;
      m_vpn[v] = vpn;
      return v;
   endfunction

   task automatic do_write(input logic [9:0] vpn, input logic [9:0] ppn);
      wr_exp_t e;
      int v;
      v = model_pick(vpn);
      e.we = 4'b0001 << v;
      e.vpn = vpn;
      e.ppn = ppn;
      exp_q.push_back(e);
      checks++;
      if (wr_ready !== 1'b1) begin
         errors++;
         $display("FAIL wr_ready_before_write: got %b want 1", wr_ready);
      end
      wr_req = 1'b1; wr_vpn = vpn; wr_ppn = ppn;
      step();
      wr_req = 1'b0;
      checks++;
      if (fetch_stall !== 1'b1 || wr_ready !== 1'b0) begin
         errors++;
         $display("FAIL write_cycle_ctrl: stall=%b ready=%b want stall=1 ready=0", fetch_stall, wr_ready);
      end
      step();
   endtask

   task automatic test_reset();
      mon_en = 1'b0;
      reset = 1'b1; wr_req = 1'b0; lookup_req = 1'b0; exc_ack = 1'b0; tlb_hit = 1'b0;
      step();
      step();
      checks++;
      if (tlb_we !== 4'b0000 || tlb_valid_we !== 4'b0000 || fetch_stall !== 1'b1 || wr_ready !== 1'b0 ||
          miss_exc !== 1'b0 || miss_vpn !== 10'h000 || init_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: we=%b vwe=%b stall=%b ready=%b exc=%b mvpn=%h done=%b want 0000 0000 1 0 0 000 0",
                  tlb_we, tlb_valid_we, fetch_stall, wr_ready, miss_exc, miss_vpn, init_done);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (tlb_we !== 4'b0001 || tlb_vpn_d !== 10'h008 || tlb_ppn_d !== 10'h000 ||
          tlb_valid_we !== 4'b1111 || tlb_valid_d !== 4'b0001 || init_done !== 1'b0) begin
         errors++;
         $display("FAIL boot0: we=%b vpn=%h ppn=%h vwe=%b vd=%b done=%b want 0001 008 000 1111 0001 0",
                  tlb_we, tlb_vpn_d, tlb_ppn_d, tlb_valid_we, tlb_valid_d, init_done);
      end
      step();
      checks++;
      if (tlb_we !== 4'b0010 || tlb_vpn_d !== 10'h009 || tlb_ppn_d !== 10'h001 ||
          tlb_valid_we !== 4'b0010 || tlb_valid_d !== 4'b0010 || init_done !== 1'b0) begin
         errors++;
         $display("FAIL boot1: we=%b vpn=%h ppn=%h vwe=%b vd=%b done=%b want 0010 009 001 0010 0010 0",
                  tlb_we, tlb_vpn_d, tlb_ppn_d, tlb_valid_we, tlb_valid_d, init_done);
      end
      step();
      checks++;
      if (init_done !== 1'b1 || tlb_we !== 4'b0000 || wr_ready !== 1'b1 || fetch_stall !== 1'b0) begin
         errors++;
         $display("FAIL boot_done: done=%b we=%b ready=%b stall=%b want 1 0000 1 0",
                  init_done, tlb_we, wr_ready, fetch_stall);
      end
      for (int i = 0; i < 4; i++) begin m_valid[i] = 1'b0; m_vpn[i] = 10'h000; end
      m_valid[0] = 1'b1; m_vpn[0] = 10'h008;
      m_valid[1] = 1'b1; m_vpn[1] = 10'h009;
      m_rr = 2;
      mon_en = 1'b1;
   endtask

   task automatic test_fill();
      do_write(10'h020, 10'h005);
      do_write(10'h021, 10'h006);
   endtask

   task automatic test_round_robin();
      do_write(10'h030, 10'h00E);
      do_write(10'h031, 10'h00F);
   endtask

   task automatic test_overwrite();
      do_write(10'h009, 10'h007);
      do_write(10'h040, 10'h010);
   endtask

   task automatic test_miss();
      lookup_req = 1'b1; tlb_hit = 1'b0; lookup_vpn = 10'h0FF;
      #1;
      checks++;
      if (fetch_stall !== 1'b0) begin
         errors++;
         $display("FAIL miss_cycle_stall: got %b want 0", fetch_stall);
      end
      step();
      lookup_req = 1'b0;
      checks++;
      if (miss_exc !== 1'b1 || miss_vpn !== 10'h0FF || fetch_stall !== 1'b1 || wr_ready !== 1'b1) begin
         errors++;
         $display("FAIL miss_entry: exc=%b mvpn=%h stall=%b ready=%b want 1 0ff 1 1",
                  miss_exc, miss_vpn, fetch_stall, wr_ready);
      end
      do_write(10'h050, 10'h00B);
      checks++;
      if (miss_exc !== 1'b1 || fetch_stall !== 1'b1) begin
         errors++;
         $display("FAIL write_returns_miss: exc=%b stall=%b want 1 1", miss_exc, fetch_stall);
      end
      exc_ack = 1'b1;
      do_write(10'h051, 10'h00C);
      checks++;
      if (miss_exc !== 1'b1) begin
         errors++;
         $display("FAIL ack_with_write: exc=%b want 1", miss_exc);
      end
      step();
      exc_ack = 1'b0;
      checks++;
      if (miss_exc !== 1'b0 || fetch_stall !== 1'b0 || miss_vpn !== 10'h0FF) begin
         errors++;
         $display("FAIL ack_clears: exc=%b stall=%b mvpn=%h want 0 0 0ff", miss_exc, fetch_stall, miss_vpn);
      end
      lookup_req = 1'b1; tlb_hit = 1'b1; lookup_vpn = 10'h123;
      step();
      lookup_req = 1'b0; tlb_hit = 1'b0;
      checks++;
      if (miss_exc !== 1'b0 || fetch_stall !== 1'b0 || miss_vpn !== 10'h0FF) begin
         errors++;
         $display("FAIL hit_no_miss: exc=%b stall=%b mvpn=%h want 0 0 0ff", miss_exc, fetch_stall, miss_vpn);
      end
   endtask

   task automatic test_write_over_miss_reset();
      logic [3:0] we_e;
      mon_en = 1'b0;
      we_e = 4'b0001 << model_pick(10'h060);
      lookup_req = 1'b1; tlb_hit = 1'b0; lookup_vpn = 10'h1AA;
      wr_req = 1'b1; wr_vpn = 10'h060; wr_ppn = 10'h00A;
      step();
      wr_req = 1'b0; lookup_req = 1'b0;
      checks++;
      if (tlb_we !== we_e || tlb_vpn_d !== 10'h060 || miss_exc !== 1'b0 || miss_vpn !== 10'h0FF) begin
         errors++;
         $display("FAIL write_beats_miss: we=%b vpn=%h exc=%b mvpn=%h want %b 060 0 0ff",
                  tlb_we, tlb_vpn_d, miss_exc, miss_vpn, we_e);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (tlb_we !== 4'b0000 || tlb_valid_we !== 4'b0000 || fetch_stall !== 1'b1 || wr_ready !== 1'b0 ||
          miss_exc !== 1'b0 || miss_vpn !== 10'h000 || init_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_write: we=%b vwe=%b stall=%b ready=%b exc=%b mvpn=%h done=%b",
                  tlb_we, tlb_valid_we, fetch_stall, wr_ready, miss_exc, miss_vpn, init_done);
      end
      test_reset();
   endtask

   task automatic test_back_to_back();
      do_write(10'h070, 10'h011);
      do_write(10'h071, 10'h012);
      do_write(10'h072, 10'h013);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d expected writes never seen, want 0", exp_q.size());
      end
   endtask

   initial begin
      reset = 1'b1; lookup_req = 1'b0; lookup_vpn = 10'h000; tlb_hit = 1'b0;
      wr_req = 1'b0; wr_vpn = 10'h000; wr_ppn = 10'h000; exc_ack = 1'b0;
`ifdef ITLB_FLUSH_EN
      flush = 1'b0;
`endif
      test_reset();
      test_fill();
      test_round_robin();
      test_overwrite();
      test_miss();
      test_write_over_miss_reset();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/itlb_ctrl.md
# itlb_ctrl

Sequencing controller for the 4-entry instruction TLB storage in FETCH. It owns every write port of the TLB: it loads the boot mappings after reset and accepts tlbwrite requests from the handler. It picks the victim entry, detects fetch-side misses, stalls fetch and raises the miss exception. The TLB storage keeps only lookup logic and registers; all `enable`/`d` inputs come from this block.

## Interface
- `num_tlb_lines`, 4, number of TLB entries; the logic below is fixed for 4.
- `tag_bits_per_addr`, 10, width of virtual and physical page numbers.

- `clk`  in  1  single clock; everything is posedge.
- `reset`  in  1  synchronous, active-high.
- `lookup_req`  in  1  fetch presents a translation this cycle.
- `lookup_vpn`  in  10  virtual page of the fetch.
- `tlb_hit`  in  1  combinational hit flag from TLB storage.
- `wr_req`  in  1  tlbwrite request.
- `wr_vpn`  in  10  virtual page to map.
- `wr_ppn`  in  10  physical page to map.
- `wr_ready`  out  1  controller can accept a write this cycle.
- `tlb_we`  out  4  one-hot entry write enable.
- `tlb_vpn_d`  out  10  virtual page to write.
- `tlb_ppn_d`  out  10  physical page to write.
- `tlb_valid_we`  out  4  per-entry valid-bit write enable.
- `tlb_valid_d`  out  4  valid-bit values.
- `fetch_stall`  out  1  fetch must hold its PC and replay.
- `miss_exc`  out  1  ITLB miss exception pending.
- `miss_vpn`  out  10  captured faulting virtual page.
- `exc_ack`  in  1  handler acknowledges the miss.
- `init_done`  out  1  boot mappings are loaded.

## Operation
- FSM states: BOOT0, BOOT1, IDLE, WRITE, MISS, plus FLUSH when configured. Outputs decode from registered state and registered shadows.
- Shadows: `sh_valid[3:0]` and `sh_vpn[0..3]` mirror TLB contents.
- Round-robin pointer `rr[1:0]`.

State behaviour:
- BOOT0:
  - `tlb_we=0001`, vpn `0x008`, ppn `0x000`.
  - `tlb_valid_we=1111`, `tlb_valid_d=0001`.
  - Next state is BOOT1.
- BOOT1:
  - `tlb_we=0010`, vpn `0x009`, ppn `0x001`.
  - `tlb_valid_we=0010`, `tlb_valid_d=0010`.
  - Next state is IDLE; `rr` is set to 2.
- IDLE:
  - `wr_ready=1`, `fetch_stall=0`.
  - Priority is flush > write > miss.
  - `wr_req` accepted: latch vpn/ppn and victim, go to WRITE.
  - Else `lookup_req && !tlb_hit`: latch `miss_vpn=lookup_vpn` and go to MISS.
- WRITE:
  - Drive `tlb_we` one-hot to the victim, plus `tlb_valid_we` and `tlb_valid_d` for that entry set to 1.
  - Update the shadows; `fetch_stall=1`, `wr_ready=0`.
  - Return to the state it came from: IDLE, or MISS if the write was accepted in MISS.
- MISS:
  - `miss_exc=1`, `fetch_stall=1`, `wr_ready=1`.
  - A write accepted here goes to WRITE, then back to MISS.
  - `exc_ack` goes to IDLE; `miss_exc` is 0 from the next cycle.
  - `exc_ack` and `wr_req` in the same cycle: the write is taken and the ack is ignored.

Victim selection, in order:
1. A valid entry whose `sh_vpn == wr_vpn`, so an existing mapping is overwritten.
2. Else the lowest-index invalid entry.
3. Else `rr`, after which `rr` increments and wraps 3 to 0. `rr` is unchanged in cases 1 and 2.

## Timing
- Reset cycle and all cycles while `reset=1`:
  - All enables are 0.
  - `fetch_stall=1`, `wr_ready=0`, `miss_exc=0`, `miss_vpn=0`, `init_done=0`.
  - Shadows are cleared, `rr=0`, state is BOOT0.
- Boot: the first cycle after reset deasserts is BOOT0 and the second is BOOT1. `init_done=1` from the third cycle onward.
- Reset asserted mid-WRITE or mid-MISS abandons the operation and boot reruns.
- Write latency: accepted at the edge ending cycle N, `tlb_we` is high in N+1, and a lookup in N+2 hits.
- Miss detection: a miss in cycle N gives `miss_exc=1` and `fetch_stall=1` in N+1. `fetch_stall` is 0 in cycle N itself, so fetch must replay that PC.
- `miss_vpn` holds its value until the next miss capture.

## Configuration
- `ITLB_FLUSH_EN` defined:
  - Adds input port `flush` (1 bit) and the FLUSH state.
  - In IDLE or MISS, `flush` goes to FLUSH for one cycle: `tlb_valid_we=1111`, `tlb_valid_d=0000`, `sh_valid=0`, `rr=0`, `fetch_stall=1`.
  - FLUSH always returns to IDLE; a pending miss is dropped.
- `ITLB_FLUSH_EN` undefined: no `flush` port and no FLUSH state.

## Test plan
- Reset for 2 cycles, then release. Required:
  - BOOT0 drives `tlb_we=0001` with vpn `0x008`/ppn `0x000` and `tlb_valid_d=0001`.
  - BOOT1 drives `tlb_we=0010` with vpn `0x009`/ppn `0x001`.
  - `init_done=1` on the third cycle.
- After boot, write vpn `0x020`→ppn `0x005`, then vpn `0x021`→ppn `0x006`. Required: `tlb_we=0100`, then `1000`; `rr` stays 2.
- With all 4 entries valid, write vpn `0x030`, then vpn `0x031`. Required: `tlb_we=0100`, then `1000`, with `rr` wrapping to 0.
- Write vpn `0x009`→ppn `0x007`. Required: `tlb_we=0010`, no new entry used, `rr` unchanged.
- `lookup_req=1`, `tlb_hit=0`, vpn `0x0FF`. Required:
  - Next cycle `miss_exc=1`, `miss_vpn=0x0FF`, `fetch_stall=1`.
  - A write during MISS returns to MISS.
  - `exc_ack` clears `miss_exc` on the following cycle.
- Assert `wr_req` and a missing lookup in the same IDLE cycle, then assert `reset` during WRITE. Required: WRITE is entered with no miss captured; reset forces BOOT0 and `miss_exc=0`.
